// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch with start/stop/pause, target-time stop and 99:59 saturation.
// One increment every DIVISOR clocks while running; all outputs are registered or decoded from the state register.
module stopwatch_counter #(
  parameter int DIVISOR = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startStop,
  input  logic       clear,
  input  logic       targetEn,
  input  logic [7:0] targetSecs,
  input  logic [7:0] targetMins,
  output logic [7:0] secs,
  output logic [7:0] mins,
  output logic       running,
  output logic       done,
  output logic       donePulse
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [7:0]    secs_nxt, mins_nxt;
  logic [7:0]    secs_inc, mins_inc;
  logic          prev_ss;
  logic          btn_edge;
  logic          tick;
  logic          at_max;
  logic          hit_target;
  logic          pulse_nxt;

  // prev_ss resets high so a button held through reset is not seen as a press
  assign btn_edge = startStop & ~prev_ss;
  assign tick     = (state == RUN) && (div_cnt == DW'(DIVISOR - 1));
  assign at_max   = (mins == 8'h99) && (secs == 8'h59);

  always_comb begin
    secs_inc = secs;
    mins_inc = mins;
    if (secs[3:0] != 4'd9) begin
      secs_inc[3:0] = secs[3:0] + 4'd1;
    end else begin
      secs_inc[3:0] = 4'd0;
      if (secs[7:4] != 4'd5) begin
        secs_inc[7:4] = secs[7:4] + 4'd1;
      end else begin
        secs_inc[7:4] = 4'd0;
        if (mins[3:0] != 4'd9) begin
          mins_inc[3:0] = mins[3:0] + 4'd1;
        end else begin
          mins_inc[3:0] = 4'd0;
          mins_inc[7:4] = mins[7:4] + 4'd1;
        end
      end
    end
  end

  // Out-of-range BCD targets simply never equal a legal count
  assign hit_target = targetEn && ({mins_inc, secs_inc} == {targetMins, targetSecs});

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    secs_nxt  = secs;
    mins_nxt  = mins;
    if (clear) begin
      state_nxt = IDLE;
      div_nxt   = '0;
      secs_nxt  = 8'h00;
      mins_nxt  = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (btn_edge) state_nxt = RUN;
        end
        RUN: begin
          div_nxt = tick ? '0 : div_cnt + 1'b1;
          if (btn_edge) state_nxt = PAUSE;
          if (tick) begin
            if (at_max) begin
              state_nxt = DONE;
            end else begin
              secs_nxt = secs_inc;
              mins_nxt = mins_inc;
              if (hit_target) state_nxt = DONE;
            end
          end
        end
        PAUSE: begin
          if (btn_edge) state_nxt = RUN;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    pulse_nxt = (state_nxt == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      secs      <= 8'h00;
      mins      <= 8'h00;
      prev_ss   <= 1'b1;
      donePulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      secs      <= secs_nxt;
      mins      <= mins_nxt;
      prev_ss   <= startStop;
      donePulse <= pulse_nxt;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at DIVISOR=4 with hand-computed expectations.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       startStop;
  logic       clear;
  logic       targetEn;
  logic [7:0] targetSecs;
  logic [7:0] targetMins;
  logic [7:0] secs;
  logic [7:0] mins;
  logic       running;
  logic       done;
  logic       donePulse;

  int total = 0;
  int bad   = 0;

  stopwatch_counter #(.DIVISOR(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .startStop  (startStop),
    .clear      (clear),
    .targetEn   (targetEn),
    .targetSecs (targetSecs),
    .targetMins (targetMins),
    .secs       (secs),
    .mins       (mins),
    .running    (running),
    .done       (done),
    .donePulse  (donePulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b0;
    startStop  = 1'b1;
    clear      = 1'b0;
    targetEn   = 1'b0;
    targetSecs = 8'h00;
    targetMins = 8'h00;

    // reset state, button held through reset
    step(3);
    chk("rst_secs", {8'h00, secs}, 16'h0000);
    chk("rst_mins", {8'h00, mins}, 16'h0000);
    chk("rst_run", {15'd0, running}, 16'd0);
    chk("rst_done", {14'd0, done, donePulse}, 16'd0);
    reset = 1'b1;
    step(3);
    chk("held_btn_idle", {15'd0, running}, 16'd0);
    startStop = 1'b0;
    step(1);

    // start and count every 4 cycles
    startStop = 1'b1;
    step(1);
    chk("start_run", {15'd0, running}, 16'd1);
    chk("start_secs", {8'h00, secs}, 16'h0000);
    startStop = 1'b0;
    step(3);
    chk("pre_tick1", {8'h00, secs}, 16'h0000);
    step(1);
    chk("tick1", {8'h00, secs}, 16'h0001);
    step(4);
    chk("tick2", {8'h00, secs}, 16'h0002);

    // pause with divider at 2, hold 20 cycles
    step(1);
    startStop = 1'b1;
    step(1);
    chk("pause_run", {15'd0, running}, 16'd0);
    startStop = 1'b0;
    step(20);
    chk("pause_hold", {8'h00, secs}, 16'h0002);
    chk("pause_run2", {15'd0, running}, 16'd0);

    // resume: increment after 2 cycles
    startStop = 1'b1;
    step(1);
    chk("resume_run", {15'd0, running}, 16'd1);
    startStop = 1'b0;
    step(1);
    chk("resume_c1", {8'h00, secs}, 16'h0002);
    step(1);
    chk("resume_c2", {8'h00, secs}, 16'h0003);

    // clear beats edge while paused
    startStop = 1'b1;
    step(1);
    startStop = 1'b0;
    step(1);
    startStop = 1'b1;
    clear = 1'b1;
    step(1);
    chk("clr_edge_run", {15'd0, running}, 16'd0);
    chk("clr_edge_cnt", {mins, secs}, 16'h0000);
    clear = 1'b0;
    startStop = 1'b0;
    step(2);
    chk("clr_edge_idle", {15'd0, running}, 16'd0);

    // target 00:03
    targetEn = 1'b1;
    targetSecs = 8'h03;
    targetMins = 8'h00;
    startStop = 1'b1;
    step(1);
    startStop = 1'b0;
    step(11);
    chk("tgt_pre_secs", {8'h00, secs}, 16'h0002);
    chk("tgt_pre_done", {15'd0, done}, 16'd0);
    step(1);
    chk("tgt_secs", {8'h00, secs}, 16'h0003);
    chk("tgt_done", {13'd0, running, done, donePulse}, 16'b011);
    step(1);
    chk("tgt_pulse_once", {14'd0, done, donePulse}, 16'b10);
    startStop = 1'b1;
    step(1);
    startStop = 1'b0;
    step(5);
    chk("done_ignore_edge", {7'd0, done, secs}, 16'h0103);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("done_clear", {7'd0, done, mins[7:0] | secs}, 16'h0000);
    chk("done_clear_cnt", {mins, secs}, 16'h0000);

    // asynchronous reset mid-run
    targetEn = 1'b0;
    startStop = 1'b1;
    step(1);
    startStop = 1'b0;
    step(5);
    chk("async_pre", {8'h00, secs}, 16'h0001);
    reset = 1'b0;
    #1;
    chk("async_secs", {8'h00, secs}, 16'h0000);
    chk("async_run", {15'd0, running}, 16'd0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("async_after", {15'd0, running}, 16'd0);

    // long run: carries, saturation; target has invalid BCD digit so never matches
    targetEn = 1'b1;
    targetMins = 8'h00;
    targetSecs = 8'h3A;
    startStop = 1'b1;
    step(1);
    startStop = 1'b0;
    step(236);
    chk("cnt_0059", {mins, secs}, 16'h0059);
    step(4);
    chk("cnt_0100", {mins, secs}, 16'h0100);
    step(2156);
    chk("cnt_0959", {mins, secs}, 16'h0959);
    step(4);
    chk("cnt_1000", {mins, secs}, 16'h1000);
    step(21596);
    chk("cnt_9959", {mins, secs}, 16'h9959);
    chk("cnt_9959_run", {14'd0, running, done}, 16'b10);
    step(4);
    chk("sat_cnt", {mins, secs}, 16'h9959);
    chk("sat_done", {13'd0, running, done, donePulse}, 16'b011);
    step(6);
    chk("sat_hold", {mins, secs}, 16'h9959);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
